pokey_audio_mixer: RTL

Downstream stage of the POKEY audio generator. Takes the four 1-bit channel waveforms plus the per-channel volume and volume-only controls, and forms a registered 6-bit instantaneous mix. It decimates that mix into PCM samples delivered over a valid/ready handshake. Optionally it also drives a 1-bit first-order delta-sigma DAC pin.

---
 rtl/pokey_mix_pkg.sv | 16 +
 rtl/pokey_dsm_dac.sv | 26 ++
 rtl/pokey_audio_mixer.sv | 118 +++++++++++
 3 files changed

// File: rtl/pokey_mix_pkg.sv
// Shared constants and the per-channel volume term for the POKEY audio mixer.
package pokey_mix_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned VOL_W  = 4;
  localparam int unsigned MIX_W  = 6;
  localparam int unsigned DSM_W  = 6;

  // Volume-only mode passes the volume straight through, ignoring the waveform.
  function automatic logic [MIX_W-1:0] chan_term(input logic [VOL_W-1:0] vol,
                                                 input logic             vol_only,
                                                 input logic             audio);
    return (vol_only || audio) ? MIX_W'(vol) : '0;
  endfunction

endpackage

// File: rtl/pokey_dsm_dac.sv
// First-order delta-sigma modulator: ones density on dac_out tracks mix_r / 64.
module pokey_dsm_dac
  import pokey_mix_pkg::*;
(
  input  logic             clk179,
  input  logic             init_L,
  input  logic [MIX_W-1:0] mix_r,
  output logic             dac_out
);

  logic [DSM_W-1:0] dsm_acc_q;
  logic [DSM_W:0]   dsm_sum;

  assign dsm_sum = {1'b0, dsm_acc_q} + {1'b0, mix_r};

  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      dsm_acc_q <= '0;
      dac_out   <= 1'b0;
    end else begin
      dsm_acc_q <= dsm_sum[DSM_W-1:0];
      dac_out   <= dsm_sum[DSM_W];
    end
  end

endmodule

// File: rtl/pokey_audio_mixer.sv
// Mixes the four POKEY channels, decimates into PCM samples over valid/ready.
// Define POKEY_MIX_DSM_EN to add the 1-bit delta-sigma DAC output.
module pokey_audio_mixer
  import pokey_mix_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = 5,
  parameter int unsigned SW         = 6 + DECIM_LOG2
) (
  input  logic          clk179,
  input  logic          init_L,
  input  logic          audio1,
  input  logic          audio2,
  input  logic          audio3,
  input  logic          audio4,
  input  logic [3:0]    vol1,
  input  logic [3:0]    vol2,
  input  logic [3:0]    vol3,
  input  logic [3:0]    vol4,
  input  logic          volOnly1,
  input  logic          volOnly2,
  input  logic          volOnly3,
  input  logic          volOnly4,
  input  logic          mute,
  input  logic          sample_ready,
  output logic          sample_valid,
  output logic [SW-1:0] sample_data,
  output logic          overrun,
  input  logic          clear_ovr,
  output logic          dac_out
);

  logic [NUM_CH-1:0] audio_in, vol_only;
  logic [VOL_W-1:0]  vol [NUM_CH];

  assign audio_in = {audio4, audio3, audio2, audio1};
  assign vol_only = {volOnly4, volOnly3, volOnly2, volOnly1};
  assign vol[0]   = vol1;
  assign vol[1]   = vol2;
  assign vol[2]   = vol3;
  assign vol[3]   = vol4;

  logic [NUM_CH-1:0]     audio_meta_q, audio_sync_q;
  logic [MIX_W-1:0]      mix_d, mix_q;
  logic [DECIM_LOG2-1:0] cnt_q;
  logic [SW-1:0]         acc_q, acc_d, result;
  logic                  win_end;
  logic                  valid_d, valid_q, ovr_d, ovr_q;
  logic [SW-1:0]         data_d, data_q;

  always_comb begin
    mix_d = '0;
    if (!mute) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mix_d = mix_d + chan_term(vol[i], vol_only[i], audio_sync_q[i]);
      end
    end
  end

  assign win_end = (cnt_q == {DECIM_LOG2{1'b1}});
  assign result  = acc_q + SW'(mix_q);

  always_comb begin
    acc_d   = win_end ? '0 : result;
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (clear_ovr) ovr_d = 1'b0;
    if (win_end) begin
      // A consumer accepting on the window-end edge frees the slot for the new result.
      if (!valid_q || sample_ready) begin
        valid_d = 1'b1;
        data_d  = result;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      audio_meta_q <= '0;
      audio_sync_q <= '0;
      mix_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      ovr_q        <= 1'b0;
    end else begin
      audio_meta_q <= audio_in;
      audio_sync_q <= audio_meta_q;
      mix_q        <= mix_d;
      cnt_q        <= cnt_q + 1'b1;
      acc_q        <= acc_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      ovr_q        <= ovr_d;
    end
  end

  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign overrun      = ovr_q;

`ifdef POKEY_MIX_DSM_EN
  pokey_dsm_dac u_dsm (
    .clk179  (clk179),
    .init_L  (init_L),
    .mix_r   (mix_q),
    .dac_out (dac_out)
  );
`else
  assign dac_out = 1'b0;
`endif

endmodule
